// File: rtl/fetch_controller.sv
// fetch_controller: owns the program counter and drives the instruction-memory
// address. Each fetched word is registered into a valid/ready output stage
// for decode. Handles branch redirects, decode back-pressure and end of program.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset; waits for start, branch requests ignored
//   RUN   | fetching; branch > done (slot free) > capture (slot free) > stall
//   HALT  | program ended; start restarts from START_ADDR
module fetch_controller #(
  parameter int unsigned          WORD_W     = 16,
  parameter int unsigned          MEM_DEPTH  = 256,
  parameter logic [WORD_W-1:0]    START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_instr,
  input  logic              imem_done,
  input  logic              branch_valid,
  input  logic [WORD_W-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc,
  output logic              halted,
  output logic              busy,
  output logic [WORD_W-1:0] fetch_count
);

  // MEM_DEPTH is a power of two, so wrapping is a mask of the low bits.
  localparam logic [WORD_W-1:0] PC_MASK = WORD_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] pc, pc_nxt;
  logic              valid_nxt;
  logic [WORD_W-1:0] instr_nxt;
  logic [WORD_W-1:0] opc_nxt;
  logic [WORD_W-1:0] count_nxt;
  logic              handshake;
  logic              slot_free;

  assign handshake = out_valid & out_ready;
  assign slot_free = ~out_valid | out_ready;

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign busy      = (state == RUN);

  // Next-state, PC and output-stage decision for the current cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = out_valid;
    instr_nxt = out_instr;
    opc_nxt   = out_pc;
    count_nxt = fetch_count;

    // Accepted handshakes count in any state; the counter sticks at all-ones.
    if (handshake && (fetch_count != '1)) begin
      count_nxt = fetch_count + WORD_W'(1);
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (branch_valid) begin
          // A flushed word is discarded even if decode took it this cycle.
          pc_nxt    = branch_target & PC_MASK;
          valid_nxt = 1'b0;
          count_nxt = fetch_count;
        end else if (slot_free && imem_done) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
        end else if (slot_free) begin
          instr_nxt = imem_instr;
          opc_nxt   = pc;
          valid_nxt = 1'b1;
          pc_nxt    = (pc + WORD_W'(1)) & PC_MASK;
        end
      end
      HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          count_nxt = '0;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, output stage and handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= START_ADDR;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fetch_count <= '0;
    end else begin
      pc          <= pc_nxt;
      out_valid   <= valid_nxt;
      out_instr   <= instr_nxt;
      out_pc      <= opc_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule
